led_bank_arbiter: RTL and testbench
===================================

Name: led_bank_arbiter

Overview:
- Time-sliced round-robin arbiter that shares the single 16-LED bank between four pattern engines (flash, shift, expand, free-running user pattern).
- Generates its own tick as a clock-enable from clk; no derived clocks.
- Sits between the pattern engines and the board LED pins. Grants one owner at a time, forwards that owner's pattern, and inserts a blank gap on every handover.

Parameters:
- TICK_DIV, 25, tick period is 2^TICK_DIV clk cycles.
- SLICE_TICKS, 8, ticks an owner may hold the bank while another requester waits (range 1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low.
- en  input  1  global run enable; 0 freezes the whole block.
- req  input  4  per-engine request, level, held while the engine wants the bank.
- release  input  4  per-engine one-cycle voluntary release pulse.
- pat_in  input  64  engine i pattern on pat_in[16i+15:16i].
- gnt  output  4  one-hot grant, registered.
- owner  output  2  index of current/last owner.
- busy  output  1  1 while in SERVE.
- tick  output  1  one-clk pulse every 2^TICK_DIV enabled cycles.
- led  output  16  LED bank drive, registered.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, gnt=0, owner=0, rr pointer=0, busy=0, led=0, tick counter=0, slice count=0, tick=0. Reset dominates en and all inputs, including mid-SERVE.
- Tick: TICK_DIV-bit counter increments on each clk while en=1. tick=1 for the one cycle in which the counter equals all ones. The counter wraps to 0.
- en=0: counter, state, gnt, owner, pointer, slice count and led all hold. tick=0. req and release are ignored.
- Winner selection: scan from pointer upward modulo 4; the first set req bit wins.

State machine (all transitions require en=1):
- IDLE:
  - led=0, gnt=0.
  - If any req bit is set, go to SERVE with the winner on the next clk. No tick is needed.
  - On entry to SERVE: gnt=onehot(winner), owner=winner, pointer=winner+1 mod 4, slice count=0.
- SERVE:
  - busy=1. led <= pat_in[owner] every clk, so led shows the pattern with 1-cycle latency.
  - Go to DRAIN if req[owner]=0, or release[owner]=1 (release takes effect even if req is still high).
  - Also go to DRAIN if tick=1, slice count=SLICE_TICKS-1, and any other req bit is set.
  - If tick=1 and slice count=SLICE_TICKS-1 with no other request, slice count clears to 0 and the owner is kept.
  - Otherwise, on tick, slice count increments.
  - On leaving SERVE: gnt=0 and busy=0 in the same cycle the state changes.
- DRAIN:
  - led=0, gnt=0. Wait for the next tick.
  - On that tick: if any req bit is set, go to SERVE with the winner (pointer already advanced past the old owner). Otherwise go to IDLE.
  - The old owner may win again only if it is the sole requester.

Boundary rules:
- release on a non-owner is ignored.
- A requester dropping req while not granted loses its place; nothing is latched.
- Simultaneous slice expiry and owner release: DRAIN, same result.
- Slice count is 8 bits and never exceeds SLICE_TICKS-1.
- With SLICE_TICKS=1, an owner is preempted on the first tick in which a competitor is present.
- gnt is always one-hot or zero. gnt is nonzero only in SERVE.

Test Plan (TICK_DIV=2, so a tick every 4 clk; SLICE_TICKS=2):
- Reset: hold rst=0 for 3 clk with req=4'b1111 -> gnt=0, led=0, busy=0, tick=0. Release rst -> the cycle after the next clk: gnt=4'b0001, owner=0, busy=1.
- Single requester: req=4'b0100, pat_in[47:32]=16'hA5A5 -> gnt=4'b0100 one clk later and led=16'hA5A5 one clk after that. It holds past 10 ticks with no DRAIN.
- Round robin: req=4'b1011 held -> owner sequence 0,1,3,0. Each owner lasts 2 ticks, with a led=0 gap of up to one tick between owners.
- Voluntary release: owner 1 pulses release[1] for one clk with req[1] still high -> next clk gnt=0, led=0. At the next tick owner=3 if req[3]=1.
- Pause: en=0 mid-SERVE for 20 clk while pat_in changes -> tick=0; led, gnt and slice count unchanged. en=1 resumes the counter from its held value.
- Reset mid-operation: rst=0 during DRAIN -> next clk is IDLE with pointer=0. With req=4'b1100, the first grant after reset is 4'b0100.

Source files
------------

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter
//   Time-sliced round-robin arbiter sharing one 16-LED bank between four
//   pattern engines. An internal clock-enable tick (every 2^TICK_DIV enabled
//   clk cycles) paces the slices; every handover passes through a blank
//   DRAIN gap that lasts until the next tick.
//
// Ports:
//   clk     system clock
//   rst     synchronous reset, active-low
//   en      global run enable; 0 freezes the whole block
//   req     [3:0]  per-engine request level
//   rel     [3:0]  per-engine one-cycle voluntary release pulse
//                  ("release" is a reserved word, hence the short name)
//   pat_in  [63:0] engine i pattern on pat_in[16i+15:16i]
//   gnt     [3:0]  one-hot grant, registered
//   owner   [1:0]  index of current/last owner
//   busy           1 while serving an owner
//   tick           one-clk pulse every 2^TICK_DIV enabled cycles
//   led     [15:0] LED bank drive, registered
module led_bank_arbiter #(
    parameter int unsigned TICK_DIV    = 25,
    parameter int unsigned SLICE_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  req,
    input  logic [3:0]  rel,
    input  logic [63:0] pat_in,
    output logic [3:0]  gnt,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        tick,
    output logic [15:0] led
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        DRAIN
    } state_t;

    localparam logic [7:0] SLICE_LAST = 8'(SLICE_TICKS - 1);

    state_t              state, state_nx;
    logic [TICK_DIV-1:0] cnt;
    logic [3:0]          gnt_nx;
    logic [1:0]          owner_nx;
    logic [1:0]          ptr, ptr_nx;
    logic [7:0]          slice, slice_nx;
    logic [15:0]         led_nx;

    logic [1:0]          win;
    logic [1:0]          idx;
    logic                any_req;
    logic [3:0]          owner_mask;
    logic                drop;
    logic                expire;
    logic                others;
    logic [15:0]         pat_sel;

    assign tick       = en && (cnt == '1);
    assign busy       = (state == SERVE);
    assign any_req    = |req;
    assign owner_mask = 4'b0001 << owner;
    assign drop       = !req[owner] || rel[owner];
    assign expire     = tick && (slice == SLICE_LAST);
    assign others     = |(req & ~owner_mask);
    assign pat_sel    = pat_in[{owner, 4'b0000} +: 16];

    // Scan from the top offset down so the lowest offset from ptr that is
    // requesting is the last one written, i.e. the round-robin winner.
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int unsigned i = 4; i > 0; i--) begin
            idx = ptr + 2'(i - 1);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        owner_nx = owner;
        ptr_nx   = ptr;
        slice_nx = slice;
        led_nx   = led;
        if (en) begin
            case (state)
                IDLE: begin
                    led_nx = '0;
                    gnt_nx = '0;
                    if (any_req) begin
                        state_nx = SERVE;
                        gnt_nx   = 4'b0001 << win;
                        owner_nx = win;
                        ptr_nx   = win + 2'd1;
                        slice_nx = '0;
                    end
                end
                SERVE: begin
                    if (drop || (expire && others)) begin
                        state_nx = DRAIN;
                        gnt_nx   = '0;
                        led_nx   = '0;
                    end else begin
                        led_nx = pat_sel;
                        if (tick) begin
                            slice_nx = expire ? '0 : slice + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    led_nx = '0;
                    gnt_nx = '0;
                    if (tick) begin
                        if (any_req) begin
                            state_nx = SERVE;
                            gnt_nx   = 4'b0001 << win;
                            owner_nx = win;
                            ptr_nx   = win + 2'd1;
                            slice_nx = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    led_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            slice <= '0;
            led   <= '0;
        end else begin
            if (en) begin
                cnt <= cnt + TICK_DIV'(1);
            end
            state <= state_nx;
            gnt   <= gnt_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
            slice <= slice_nx;
            led   <= led_nx;
        end
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter
//   Directed bench for led_bank_arbiter with TICK_DIV=2 (tick every 4 clk)
//   and SLICE_TICKS=2. Expected values are hand-derived edge by edge.
module tb_led_bank_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [3:0]  rel;
    logic [63:0] pat_in;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic        tick;
    logic [15:0] led;

    int checks = 0;
    int errors = 0;

    led_bank_arbiter #(
        .TICK_DIV(2),
        .SLICE_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .req(req),
        .rel(rel),
        .pat_in(pat_in),
        .gnt(gnt),
        .owner(owner),
        .busy(busy),
        .tick(tick),
        .led(led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b0;
        en  = 1'b1;
        rel = 4'b0000;
        req = r;
        step(2);
        rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        en     = 1'b1;
        req    = 4'b1111;
        rel    = 4'b0000;
        pat_in = {16'h3333, 16'hA5A5, 16'h2222, 16'h1111};

        // Reset holds everything clear even with all requests up
        step(3);
        chk("rst_gnt",   gnt,   4'b0000);
        chk("rst_led",   led,   16'h0000);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_tick",  tick,  1'b0);
        chk("rst_owner", owner, 2'd0);
        rst = 1'b1;
        step(1);
        chk("post_rst_gnt",   gnt,   4'b0001);
        chk("post_rst_owner", owner, 2'd0);
        chk("post_rst_busy",  busy,  1'b1);

        // Single requester holds indefinitely
        do_reset(4'b0100);
        step(1);
        chk("single_gnt",   gnt,   4'b0100);
        chk("single_owner", owner, 2'd2);
        chk("single_led0",  led,   16'h0000);
        chk("single_tick0", tick,  1'b0);
        step(1);
        chk("single_led",   led,   16'hA5A5);
        step(1);
        chk("single_tick",  tick,  1'b1);
        step(44);
        chk("single_hold_gnt",  gnt,  4'b0100);
        chk("single_hold_busy", busy, 1'b1);
        chk("single_hold_led",  led,  16'hA5A5);

        // Round robin over req=1011: owners 0,1,3,0
        pat_in = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
        do_reset(4'b1011);
        step(1);
        chk("rr_e1_owner", owner, 2'd0);
        chk("rr_e1_gnt",   gnt,   4'b0001);
        step(1);
        chk("rr_e2_led",   led,   16'hA000);
        step(5);
        chk("rr_e7_gnt",   gnt,   4'b0001);
        step(1);
        chk("rr_e8_gnt",   gnt,   4'b0000);
        chk("rr_e8_busy",  busy,  1'b0);
        chk("rr_e8_led",   led,   16'h0000);
        chk("rr_e8_owner", owner, 2'd0);
        step(4);
        chk("rr_e12_owner", owner, 2'd1);
        chk("rr_e12_gnt",   gnt,   4'b0010);
        step(1);
        chk("rr_e13_led",   led,   16'hB001);
        step(11);
        chk("rr_e24_owner", owner, 2'd3);
        chk("rr_e24_gnt",   gnt,   4'b1000);
        step(12);
        chk("rr_e36_owner", owner, 2'd0);
        chk("rr_e36_gnt",   gnt,   4'b0001);

        // Voluntary release; release on a non-owner is ignored
        do_reset(4'b1010);
        step(1);
        chk("rel_e1_owner", owner, 2'd1);
        rel = 4'b1000;
        step(1);
        chk("rel_nonowner_gnt", gnt, 4'b0010);
        chk("rel_nonowner_led", led, 16'hB001);
        rel = 4'b0010;
        step(1);
        rel = 4'b0000;
        chk("rel_gnt",  gnt,  4'b0000);
        chk("rel_led",  led,  16'h0000);
        chk("rel_busy", busy, 1'b0);
        chk("rel_tick", tick, 1'b1);
        step(1);
        chk("rel_next_owner", owner, 2'd3);
        chk("rel_next_gnt",   gnt,   4'b1000);

        // Pause mid-SERVE with the counter at all ones and slice at its last value
        pat_in = {16'hD003, 16'hC002, 16'hB001, 16'h5A5A};
        do_reset(4'b0011);
        step(1);
        chk("pause_owner", owner, 2'd0);
        step(6);
        chk("pause_pre_led",  led,  16'h5A5A);
        chk("pause_pre_tick", tick, 1'b1);
        en  = 1'b0;
        req = 4'b0010;
        #1;
        chk("pause_tick_gated", tick, 1'b0);
        for (int i = 0; i < 20; i++) begin
            pat_in[15:0] = 16'hFFFF ^ 16'(i);
            step(1);
        end
        chk("pause_led",  led,  16'h5A5A);
        chk("pause_gnt",  gnt,  4'b0001);
        chk("pause_tick", tick, 1'b0);
        en           = 1'b1;
        req          = 4'b0011;
        pat_in[15:0] = 16'h5A5A;
        #1;
        chk("resume_tick", tick, 1'b1);
        step(1);
        chk("resume_expire_gnt",  gnt,  4'b0000);
        chk("resume_expire_busy", busy, 1'b0);

        // Reset during DRAIN returns to IDLE with pointer cleared
        rst = 1'b0;
        req = 4'b1100;
        step(1);
        chk("mid_rst_gnt",   gnt,   4'b0000);
        chk("mid_rst_busy",  busy,  1'b0);
        chk("mid_rst_led",   led,   16'h0000);
        chk("mid_rst_owner", owner, 2'd0);
        chk("mid_rst_tick",  tick,  1'b0);
        rst = 1'b1;
        step(1);
        chk("mid_rst_first_gnt",   gnt,   4'b0100);
        chk("mid_rst_first_owner", owner, 2'd2);
        chk("mid_rst_first_busy",  busy,  1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
